// File: rtl/cpu_pkg.sv
// Shared word width and ALU operand-select encodings used by the datapath
// primitives and their call sites.
package cpu_pkg;

  localparam int WORD_WIDTH = 16;

  // ALU operand A selector (mux4)
  localparam logic [1:0] ALU_A_PROGRAM_COUNTER         = 2'b00;
  localparam logic [1:0] ALU_A_SOURCE                  = 2'b01;
  localparam logic [1:0] ALU_A_IMMEDIATE_SIGN_EXTENDED = 2'b10;
  localparam logic [1:0] ALU_A_IMMEDIATE_ZERO_EXTENDED = 2'b11;

  // ALU operand B selector (mux2)
  localparam logic ALU_B_DESTINATION  = 1'b0;
  localparam logic ALU_B_CONSTANT_ONE = 1'b1;

endpackage

// File: rtl/flop_enable_reset.sv
// Register with load enable and asynchronous active-low clear; the core
// storage primitive (PC, IR, status registers).
module flop_enable_reset #(
  parameter int WIDTH = cpu_pkg::WORD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset dominates a coincident clock edge; enable is only looked at once reset is released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/flop_reset.sv
// Plain register with asynchronous active-low clear: the enabled flop with
// its load enable permanently asserted.
module flop_reset #(
  parameter int WIDTH = cpu_pkg::WORD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  flop_enable_reset #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .d      (d),
    .q      (q)
  );

endmodule

// File: rtl/mux2.sv
// Two-way combinational selector (ALU operand B). An unknown select falls
// to the default branch and yields d0.
module mux2
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (s)
      ALU_B_DESTINATION:  y = d0;
      ALU_B_CONSTANT_ONE: y = d1;
      default:            y = d0;
    endcase
  end

endmodule

// File: rtl/mux4.sv
// Four-way combinational selector (ALU operand A). An unknown select falls
// to the default branch and yields d0.
module mux4
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (s)
      ALU_A_PROGRAM_COUNTER:         y = d0;
      ALU_A_SOURCE:                  y = d1;
      ALU_A_IMMEDIATE_SIGN_EXTENDED: y = d2;
      ALU_A_IMMEDIATE_ZERO_EXTENDED: y = d3;
      default:                       y = d0;
    endcase
  end

endmodule

// File: rtl/storage_mux_primitives.sv
// Bundling wrapper: one instance of each datapath primitive at a common
// WIDTH. Pure wiring, no logic of its own.
module storage_mux_primitives
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_enabled,
  output logic [WIDTH-1:0] q,
  input  logic             select2,
  input  logic [1:0]       select4,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y4
);

  flop_enable_reset #(.WIDTH(WIDTH)) u_flop_enable_reset (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .d      (d),
    .q      (q_enabled)
  );

  flop_reset #(.WIDTH(WIDTH)) u_flop_reset (
    .clock (clock),
    .reset (reset),
    .d     (d),
    .q     (q)
  );

  mux2 #(.WIDTH(WIDTH)) u_mux2 (
    .d0 (in0),
    .d1 (in1),
    .s  (select2),
    .y  (y2)
  );

  mux4 #(.WIDTH(WIDTH)) u_mux4 (
    .d0 (in0),
    .d1 (in1),
    .d2 (in2),
    .d3 (in3),
    .s  (select4),
    .y  (y4)
  );

endmodule

// File: tb/tb_storage_mux_primitives.sv
// Bench for storage_mux_primitives at WIDTH=16 and WIDTH=8: directed
// scenarios followed by randomized cycles against a reference model.
module tb_storage_mux_primitives;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- DUT signals ----------------
  logic        enable;
  logic        select2;
  logic [1:0]  select4;
  logic [15:0] d, q, q_enabled, in0, in1, in2, in3, y2, y4;
  logic [7:0]  d8, q8, qe8, in8_0, in8_1, in8_2, in8_3, y2_8, y4_8;

  storage_mux_primitives #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .d(d),
    .q_enabled(q_enabled), .q(q), .select2(select2), .select4(select4),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .y2(y2), .y4(y4)
  );

  storage_mux_primitives #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .enable(enable), .d(d8),
    .q_enabled(qe8), .q(q8), .select2(select2), .select4(select4),
    .in0(in8_0), .in1(in8_1), .in2(in8_2), .in3(in8_3), .y2(y2_8), .y4(y4_8)
  );

  // ---------------- reference model ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [15:0] exp_q, exp_qe;
  logic [7:0]  exp_q8, exp_qe8;

  // Model a rising edge: a register captures the value present at the edge
  // (if reset is released), then outputs are sampled 1 time unit later.
  task automatic step();
    if (reset) begin
      exp_q  = d;
      exp_q8 = d8;
      if (enable) begin
        exp_qe  = d;
        exp_qe8 = d8;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_flops(input string tag);
    check({tag, "_q"},    q,                exp_q);
    check({tag, "_qe"},   q_enabled,        exp_qe);
    check({tag, "_q8"},   {8'h00, q8},      {8'h00, exp_q8});
    check({tag, "_qe8"},  {8'h00, qe8},     {8'h00, exp_qe8});
  endtask

  // Async clear: model goes to zero the moment reset is seen low.
  task automatic pulse_reset_between_edges(input string tag);
    #2;
    reset = 1'b0;
    exp_q = '0; exp_qe = '0; exp_q8 = '0; exp_qe8 = '0;
    #1;
    check_flops(tag);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_muxes(input string tag);
    logic [15:0] ins  [4];
    logic [7:0]  ins8 [4];
    ins  = '{in0, in1, in2, in3};
    ins8 = '{in8_0, in8_1, in8_2, in8_3};
    #1;
    check({tag, "_y2"},  y2,            ins[{1'b0, select2}]);
    check({tag, "_y4"},  y4,            ins[select4]);
    check({tag, "_y2_8"}, {8'h00, y2_8}, {8'h00, ins8[{1'b0, select2}]});
    check({tag, "_y4_8"}, {8'h00, y4_8}, {8'h00, ins8[select4]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; enable = 1'b0; d = '0; d8 = '0;
    select2 = 1'b0; select4 = 2'b00;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    in8_0 = '0; in8_1 = '0; in8_2 = '0; in8_3 = '0;
    exp_q = '0; exp_qe = '0; exp_q8 = '0; exp_qe8 = '0;

    // Reset state while held in reset across clocks
    step(); step();
    check_flops("rst_state");
    reset = 1'b1;

    // 1: async reset with no clock edge, then held through clocks
    enable = 1'b1; d = 16'hBEEF; d8 = 8'hBE;
    step();
    check_flops("load_beef");
    #2;
    reset = 1'b0;
    exp_q = '0; exp_qe = '0; exp_q8 = '0; exp_qe8 = '0;
    #1;
    check_flops("async_rst");
    step(); step();
    check_flops("rst_held");
    #1;
    reset = 1'b1;

    // 2: plain flop follows d one cycle later (also 8-bit)
    d = 16'h1234; d8 = 8'hA5;
    step();
    check_flops("plain_1234");
    d = 16'h5678; d8 = 8'h5A;
    step();
    check_flops("plain_5678");

    // 3: enable gating
    d = 16'h00AA; d8 = 8'h0A; enable = 1'b1;
    step();
    check_flops("en_load_aa");
    enable = 1'b0; d = 16'hFFFF; d8 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_flops("en_hold");
    end
    enable = 1'b1;
    step();
    check_flops("en_load_ffff");

    // 4: reset pulse mid-stream, first edge after release reloads d
    d = 16'h0001; d8 = 8'h01; enable = 1'b1;
    step();
    check_flops("stream_1");
    pulse_reset_between_edges("mid_rst");
    step();
    check_flops("post_rst_reload");

    // 5/6: mux sweep with fixed patterns at both widths
    in0 = 16'h1111; in1 = 16'h2222; in2 = 16'h3333; in3 = 16'h4444;
    in8_0 = 8'hA5; in8_1 = 8'h5A; in8_2 = 8'hC3; in8_3 = 8'h3C;
    for (int s = 0; s < 4; s++) begin
      select2 = s[0];
      select4 = s[1:0];
      check_muxes("mux_sweep");
    end
    // explicit expectation spot-checks against literal patterns
    select2 = 1'b1; select4 = 2'b10;
    #1;
    check("mux2_lit", y2, 16'h2222);
    check("mux4_lit", y4, 16'h3333);
    check("mux4_lit8", {8'h00, y4_8}, 16'h00C3);
    select4 = 2'bxx;
    #1;
    check("mux4_x_sel", y4, 16'h1111);

    // Randomized cycles with occasional mid-cycle reset pulses
    for (int n = 0; n < 60; n++) begin
      d = 16'($urandom); d8 = 8'($urandom);
      enable = 1'($urandom_range(0, 1));
      in0 = 16'($urandom); in1 = 16'($urandom); in2 = 16'($urandom); in3 = 16'($urandom);
      in8_0 = 8'($urandom); in8_1 = 8'($urandom); in8_2 = 8'($urandom); in8_3 = 8'($urandom);
      select2 = 1'($urandom_range(0, 1));
      select4 = 2'($urandom_range(0, 3));
      check_muxes("rand_mux");
      step();
      check_flops("rand_flop");
      if ($urandom_range(0, 9) == 0) pulse_reset_between_edges("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #50000;
    $display("FAIL timeout: observed no completion, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
